alu_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer front end.
package alu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned ONEHOT_W = 7;
  localparam int unsigned FLAG_W   = 3;

  // Flag bit positions in rsp_flags and alu_fo
  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_POS   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOT = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STAGE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_CAPT  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Op code to ALU one-hot select; the reserved code selects nothing.
  function automatic logic [ONEHOT_W-1:0] op_onehot(input logic [OP_W-1:0] op);
    logic [ONEHOT_W-1:0] oh;
    oh = '0;
    case (op_e'(op))
      OP_ADD:  oh = 7'b000_0001;
      OP_SUB:  oh = 7'b000_0010;
      OP_AND:  oh = 7'b000_0100;
      OP_OR:   oh = 7'b000_1000;
      OP_NOT:  oh = 7'b001_0000;
      OP_SHL:  oh = 7'b010_0000;
      OP_SHR:  oh = 7'b100_0000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response channel between the control unit and the ALU sequencer.
interface alu_sequencer_if;

  logic                         req_valid;
  logic                         req_ready;
  logic [alu_pkg::OP_W-1:0]     req_op;
  logic [alu_pkg::DATA_W-1:0]   req_a;
  logic [alu_pkg::DATA_W-1:0]   req_b;
  logic                         req_chain;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [alu_pkg::DATA_W-1:0]   rsp_d;
  logic [alu_pkg::FLAG_W-1:0]   rsp_flags;

  // Control unit side
  modport master (
    output req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_flags
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_flags
  );

endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: operand write, staging, output
// enable, result capture, then a held response until accepted.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned STAGE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_sequencer_if.slave      bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [DATA_W-1:0]   alu_fi,
  output logic [ONEHOT_W-1:0] alu_op,
  output logic                alu_wa,
  output logic                alu_wb,
  output logic                alu_oe,
  input  logic [DATA_W-1:0]   alu_d,
  input  logic [DATA_W-1:0]   alu_fo
);

  localparam int unsigned CNT_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hs_c;
  logic             capt_c;
  logic             carry;
  logic             fo_unused;

  // Upper ALU flag bits carry nothing the response needs
  assign fo_unused = &{1'b0, alu_fo[DATA_W-1:FLAG_W]};

  // State and staging counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; STAGE lasts STAGE_CYCLES cycles via the down-counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hs_c      = 1'b0;
    capt_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          hs_c      = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_nxt   = CNT_W'(STAGE_CYCLES - 1);
        state_nxt = ST_STAGE;
      end
      ST_STAGE: begin
        if (cnt == '0) begin
          state_nxt = ST_EXEC;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        capt_c    = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: strobes follow the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_d     <= '0;
      bus.rsp_flags <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_fi        <= '0;
      alu_op        <= '0;
      alu_wa        <= 1'b0;
      alu_wb        <= 1'b0;
      alu_oe        <= 1'b0;
      carry         <= 1'b0;
    end else begin
      bus.req_ready <= (state_nxt == ST_IDLE);
      bus.rsp_valid <= (state_nxt == ST_RESP);
      alu_wa        <= (state_nxt == ST_LOAD);
      alu_wb        <= (state_nxt == ST_LOAD);
      alu_oe        <= (state_nxt == ST_EXEC);

      // Operand, opcode and carry-in stay put from LOAD until back in IDLE
      if (hs_c) begin
        alu_a  <= bus.req_a;
        alu_b  <= bus.req_b;
        alu_fi <= {{(DATA_W-1){1'b0}}, carry & bus.req_chain};
        alu_op <= op_onehot(bus.req_op);
      end else if (state_nxt == ST_IDLE) begin
        alu_op <= '0;
      end

      // ALU result is only driven in the cycle after output enable
      if (capt_c) begin
        bus.rsp_d     <= alu_d;
        bus.rsp_flags <= alu_fo[FLAG_W-1:0];
        carry         <= alu_fo[FLAG_CARRY];
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural ALU and a spec-level result model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int STAGE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_a, alu_b, alu_fi, alu_d, alu_fo;
  logic [6:0] alu_op;
  logic       alu_wa, alu_wb, alu_oe;

  int checks = 0;
  int errors = 0;
  bit model_carry;
  logic [7:0] last_d;
  logic [2:0] last_f;

  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer #(.STAGE_CYCLES(STAGE)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fi(alu_fi), .alu_op(alu_op),
    .alu_wa(alu_wa), .alu_wb(alu_wb), .alu_oe(alu_oe),
    .alu_d(alu_d), .alu_fo(alu_fo)
  );

  // Behavioural ALU: operands latched on strobes, shifts read the raw buses,
  // result registered on output enable and undriven otherwise.
  logic [7:0] la, lb;

  function automatic logic [15:0] alu_eval(input logic [6:0] oh, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] sa,
                                           input logic [7:0] sb, input logic ci);
    logic [8:0] s;
    s = '0;
    if (oh[0])      s = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    else if (oh[1]) s = {1'b0, a} - {1'b0, b} - {8'b0, ci};
    else if (oh[2]) s = {1'b0, a & b};
    else if (oh[3]) s = {1'b0, a | b};
    else if (oh[4]) s = {1'b0, ~a};
    else if (oh[5]) s = {1'b0, sa << sb};
    else if (oh[6]) s = {1'b0, sa >> sb};
    return {5'b0, (s[7:0] != 8'h00) && !s[7], s[7:0] == 8'h00, s[8], s[7:0]};
  endfunction

  always @(posedge clk) begin
    if (alu_wa) la <= alu_a;
    if (alu_wb) lb <= alu_b;
    if (alu_oe) {alu_fo, alu_d} <= alu_eval(alu_op, la, lb, alu_a, alu_b, alu_fi[0]);
    else begin
      alu_d  <= 8'hxx;
      alu_fo <= 8'hxx;
    end
  end

  // Reference result {pos, zero, carry, d} from op code and integer arithmetic
  function automatic logic [10:0] ref_op(input int op, input int a, input int b, input int cin);
    int r;
    bit c;
    logic [7:0] d;
    c = 1'b0;
    case (op)
      0: begin r = a + b + cin; c = (r > 255); end
      1: begin r = a - b - cin; c = (r < 0); end
      2: r = a & b;
      3: r = a | b;
      4: r = ~a;
      5: r = (b > 7) ? 0 : (a << b);
      6: r = (b > 7) ? 0 : (a >> b);
      default: r = 0;
    endcase
    d = 8'(r & 255);
    return {(d != 0) && (d < 128), d == 0, c, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {17'b0, bus.req_ready, bus.rsp_valid, bus.rsp_d, bus.rsp_flags,
            alu_a, alu_b, alu_fi, alu_op, alu_wa, alu_wb, alu_oe};
  endfunction

  // Present a request and return at the negedge after its handshake edge
  task automatic issue(input int op, input logic [7:0] a, input logic [7:0] b, input bit chain);
    int n;
    bus.req_op    = 3'(op);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_chain = chain;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Follow the operation from LOAD to RESP and check the response
  task automatic collect(input int op, input logic [7:0] a, input logic [7:0] b, input bit chain);
    int cyc;
    logic [10:0] e;
    logic [6:0] exp_oh;
    logic [2:0] exp_str;
    bit cin;
    cin    = chain & model_carry;
    e      = ref_op(op, int'(a), int'(b), int'(cin));
    exp_oh = (op == 7) ? 7'b0 : 7'(1 << op);
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 64) begin
      exp_str = (cyc == 1) ? 3'b110 : ((cyc == 2 + STAGE) ? 3'b001 : 3'b000);
      check("alu_a_stable", 64'(alu_a), 64'(a));
      check("alu_b_stable", 64'(alu_b), 64'(b));
      check("alu_op_stable", 64'(alu_op), 64'(exp_oh));
      check("alu_fi", 64'(alu_fi), 64'(cin));
      check("strobes", 64'({alu_wa, alu_wb, alu_oe}), 64'(exp_str));
      check("req_ready_busy", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(4 + STAGE));
    check("rsp_d", 64'(bus.rsp_d), 64'(e[7:0]));
    check("rsp_flags", 64'(bus.rsp_flags), 64'(e[10:8]));
    check("resp_alu_op", 64'(alu_op), 64'(exp_oh));
    model_carry = e[8];
    last_d = bus.rsp_d;
    last_f = bus.rsp_flags;
  endtask

  // Hold the response under backpressure, then accept it
  task automatic release_rsp(input int hold);
    logic [7:0] d0;
    logic [2:0] f0;
    d0 = bus.rsp_d;
    f0 = bus.rsp_flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_hold", 64'({bus.rsp_d, bus.rsp_flags}), 64'({d0, f0}));
      check("bp_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_done", 64'(bus.rsp_valid), 64'd0);
    check("idle_ready", 64'(bus.req_ready), 64'd1);
    check("idle_ctrl", 64'({alu_op, alu_wa, alu_wb, alu_oe}), 64'd0);
  endtask

  task automatic run(input int op, input logic [7:0] a, input logic [7:0] b,
                     input bit chain, input int hold);
    issue(op, a, b, chain);
    collect(op, a, b, chain);
    release_rsp(hold);
  endtask

  initial begin
    int op;
    logic [7:0] a, b;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_chain = 1'b0;
    bus.rsp_ready = 1'b0;
    model_carry   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);
    check("idle_alu_op", 64'(alu_op), 64'd0);

    // Directed cases
    run(0, 8'h7F, 8'h01, 1'b0, 0);
    check("add7f_d", 64'(last_d), 64'h80);
    check("add7f_f", 64'(last_f), 64'b000);
    run(0, 8'hFF, 8'h01, 1'b0, 1);
    check("addff_d", 64'(last_d), 64'h00);
    check("addff_f", 64'(last_f), 64'b011);
    run(0, 8'h00, 8'h00, 1'b1, 0);
    check("chain_d", 64'(last_d), 64'h01);
    check("chain_f", 64'(last_f), 64'b100);
    run(1, 8'h05, 8'h07, 1'b0, 0);
    check("sub_d", 64'(last_d), 64'hFE);
    check("sub_f", 64'(last_f), 64'b001);
    run(5, 8'h03, 8'h02, 1'b0, 0);
    check("shl_d", 64'(last_d), 64'h0C);
    run(7, 8'h55, 8'hAA, 1'b0, 2);
    check("rsv_d", 64'(last_d), 64'h00);
    check("rsv_f", 64'(last_f), 64'b010);

    // Backpressure with a waiting request, accepted only after the response
    issue(0, 8'hFF, 8'h01, 1'b0);
    collect(0, 8'hFF, 8'h01, 1'b0);
    bus.req_op = 3'd0; bus.req_a = 8'h10; bus.req_b = 8'h20; bus.req_chain = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp2_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp2_d", 64'(bus.rsp_d), 64'h00);
      check("bp2_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("sim_rsp_done", 64'(bus.rsp_valid), 64'd0);
    check("sim_idle_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("sim_accepted", 64'({bus.req_ready, alu_wa}), 64'b01);
    collect(0, 8'h10, 8'h20, 1'b1);
    check("sim_chain_d", 64'(last_d), 64'h31);
    release_rsp(0);

    // Reset during EXEC after a carry-producing op
    run(0, 8'hFF, 8'h01, 1'b0, 0);
    issue(0, 8'h80, 8'h80, 1'b1);
    repeat (STAGE + 1) @(negedge clk);
    check("in_exec", 64'(alu_oe), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", outs(), 64'd0);
    rst = 1'b0;
    model_carry = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    run(0, 8'h01, 8'h01, 1'b1, 0);
    check("carry_cleared", 64'(last_d), 64'h02);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = (op == 5 || op == 6) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      run(op, a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
